// File: rtl/puf_eval_ctrl.sv
// RO-PUF measurement sequencer: clear, enable window, settle, compare,
// shift one response bit per challenge, pulse resp_valid when complete.
//
// Ports:
//   clk        system clock
//   rst_n      async reset, active-high (1 = reset)
//   start      begin a run (accepted in IDLE only, ignored with abort)
//   abort      synchronous cancel of a run in progress
//   chal_seed  first challenge of the run
//   cnt_a/b    oscillator counts from arrays A and B
//   ro_en      oscillator enable
//   cnt_clr    counter clear, active-high
//   chal       current challenge / RO select
//   busy       high in every state except IDLE
//   resp       response word, bit k = result of k-th challenge
//   resp_valid one-cycle pulse when resp is complete
//   tie_cnt    number of equal-count compares this run (saturating)
module puf_eval_ctrl #(
  parameter int CNT_W     = 8,
  parameter int CHAL_W    = 5,
  parameter int RESP_BITS = 8,
  parameter int CLR_CYC   = 2,
  parameter int WINDOW    = 64,
  parameter int SETTLE    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAL_W-1:0]    chal_seed,
  input  logic [CNT_W-1:0]     cnt_a,
  input  logic [CNT_W-1:0]     cnt_b,
  output logic                 ro_en,
  output logic                 cnt_clr,
  output logic [CHAL_W-1:0]    chal,
  output logic                 busy,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  output logic [5:0]           tie_cnt
);

  localparam int CW = 16;
  localparam int IW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_CMP,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CHAL_W-1:0]    chal_q, chal_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [5:0]           tie_q, tie_d;
  logic                 ro_en_q, ro_en_d;
  logic                 clr_q, clr_d;
  logic                 busy_q, busy_d;
  logic                 vld_q, vld_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      chal_q  <= '0;
      resp_q  <= '0;
      tie_q   <= '0;
      ro_en_q <= 1'b0;
      clr_q   <= 1'b1;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      ro_en_q <= ro_en_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + CW'(1);
    idx_d   = idx_q;
    chal_d  = chal_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    unique case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (start && !abort) begin
          state_d = S_CLEAR;
          chal_d  = chal_seed;
          resp_d  = '0;
          tie_d   = '0;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cyc_q == CW'(CLR_CYC - 1)) begin
          state_d = S_RUN;
          cyc_d   = '0;
        end
      end
      S_RUN: begin
        if (cyc_q == CW'(WINDOW - 1)) begin
          state_d = S_SETTLE;
          cyc_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cyc_q == CW'(SETTLE - 1)) begin
          state_d = S_CMP;
          cyc_d   = '0;
        end
      end
      S_CMP: begin
        cyc_d         = '0;
        resp_d[idx_q] = (cnt_a > cnt_b);
        if (cnt_a == cnt_b && tie_q != 6'd63)
          tie_d = tie_q + 6'd1;
        if (idx_q == IW'(RESP_BITS - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CLEAR;
          idx_d   = idx_q + IW'(1);
          chal_d  = chal_q + CHAL_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
    endcase
    // Abort overrides everything, including a pending compare.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      idx_d   = idx_q;
      chal_d  = chal_q;
      resp_d  = resp_q;
      tie_d   = tie_q;
    end
    // Outputs are decoded from the next state so they are registered.
    ro_en_d = (state_d == S_RUN);
    clr_d   = (state_d == S_IDLE) || (state_d == S_CLEAR);
    busy_d  = (state_d != S_IDLE);
    vld_d   = (state_d == S_DONE);
  end

  assign ro_en      = ro_en_q;
  assign cnt_clr    = clr_q;
  assign chal       = chal_q;
  assign busy       = busy_q;
  assign resp       = resp_q;
  assign resp_valid = vld_q;
  assign tie_cnt    = tie_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: random count tables per
// challenge, scoreboard of expected responses, decoupled monitor.
module tb_puf_eval_ctrl;

  localparam int CNT_W  = 8;
  localparam int CHAL_W = 5;
  localparam int RB     = 4;
  localparam int BIT_CYC = 2 + 4 + 2 + 1;
  localparam int RUN_LEN = RB * BIT_CYC + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CHAL_W-1:0] chal_seed = '0;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             ro_en, cnt_clr, busy, resp_valid;
  logic [CHAL_W-1:0] chal;
  logic [RB-1:0]    resp;
  logic [5:0]       tie_cnt;

  logic [7:0] tab_a [32];
  logic [7:0] tab_b [32];

  assign cnt_a = tab_a[chal];
  assign cnt_b = tab_b[chal];

  puf_eval_ctrl #(
    .CNT_W(CNT_W), .CHAL_W(CHAL_W), .RESP_BITS(RB),
    .CLR_CYC(2), .WINDOW(4), .SETTLE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .chal_seed(chal_seed), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .ro_en(ro_en), .cnt_clr(cnt_clr), .chal(chal), .busy(busy),
    .resp(resp), .resp_valid(resp_valid), .tie_cnt(tie_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RB-1:0]      resp;
    logic [5:0]         tie;
    logic [RB*5-1:0]    seq;
  } exp_t;

  exp_t sb[$];
  logic [4:0] obs[$];
  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_push = 0;
  bit disturb = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: response bit k is A>B for challenge seed+k (mod 32).
  function automatic exp_t model(input int seed);
    exp_t e;
    e = '0;
    for (int k = 0; k < RB; k++) begin
      int c;
      c = (seed + k) % 32;
      e.seq[k*5 +: 5] = 5'(c);
      if (tab_a[c] > tab_b[c]) e.resp[k] = 1'b1;
      if (tab_a[c] == tab_b[c] && e.tie < 63) e.tie = e.tie + 6'd1;
    end
    return e;
  endfunction

  // Monitor
  int   ro_hi = 0, clr_hi = 0, busy_cyc = 0;
  logic prev_ro = 1'b0;
  logic [4:0] win_chal = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (ro_en && cnt_clr) begin
        errors++;
        $display("FAIL overlap: ro_en and cnt_clr both 1");
      end
      if (ro_en && !prev_ro) begin
        if (!disturb) chk("clr_len", clr_hi, 2);
        obs.push_back(chal);
        win_chal = chal;
      end
      if (ro_en) chk("chal_stable", chal, win_chal);
      if (!ro_en && prev_ro && !disturb) chk("win_len", ro_hi, 4);
      ro_hi    = ro_en ? ro_hi + 1 : 0;
      clr_hi   = (busy && cnt_clr) ? clr_hi + 1 : 0;
      busy_cyc = busy ? busy_cyc + 1 : 0;
      if (resp_valid) begin
        n_valid++;
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_valid: resp=%0h expected none", resp);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp", resp, e.resp);
          chk("tie_cnt", tie_cnt, e.tie);
          chk("valid_cycle", busy_cyc, RUN_LEN);
          chk("n_windows", obs.size(), RB);
          for (int k = 0; k < RB && k < obs.size(); k++)
            chk("chal_seq", obs[k], e.seq[k*5 +: 5]);
        end
      end
      if (!busy) obs.delete();
      prev_ro = ro_en;
    end else begin
      prev_ro = 1'b0;
      ro_hi = 0; clr_hi = 0; busy_cyc = 0;
      obs.delete();
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    if (i == 200) begin
      errors++; checks++;
      $display("FAIL idle_timeout: busy=%0d expected 0", busy);
    end
  endtask

  task automatic run_full(input int seed, input bit glitch);
    wait_idle();
    chal_seed = 5'(seed);
    start = 1'b1;
    sb.push_back(model(seed));
    n_push++;
    @(posedge clk); #1;
    start = 1'b0;
    if (glitch) begin
      repeat (10) @(posedge clk);
      #1; start = 1'b1;
      chal_seed = 5'(seed + 13);
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ro_en"}, ro_en, 0);
    chk({tag, "_cnt_clr"}, cnt_clr, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_chal"}, chal, 0);
    chk({tag, "_resp"}, resp, 0);
    chk({tag, "_valid"}, resp_valid, 0);
    chk({tag, "_tie"}, tie_cnt, 0);
  endtask

  initial begin
    int v0;
    for (int i = 0; i < 32; i++) begin
      tab_a[i] = 8'(i);
      tab_b[i] = 8'(31 - i);
    end
    // 1. Reset
    repeat (3) @(posedge clk);
    #1; chk_reset_vals("rst_held");
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("rst_rel");

    // 2. Directed run, seed 5
    tab_a[5] = 9; tab_b[5] = 3;
    tab_a[6] = 2; tab_b[6] = 7;
    tab_a[7] = 8; tab_b[7] = 1;
    tab_a[8] = 4; tab_b[8] = 6;
    run_full(5, 0);
    chk("s2_resp_const", resp, 4'b0101);

    // 4. All ties
    for (int i = 0; i < 32; i++) begin
      tab_a[i] = 8'h80;
      tab_b[i] = 8'h80;
    end
    run_full(12, 0);
    chk("s4_resp_const", resp, 0);
    chk("s4_tie_const", tie_cnt, 4);

    // 5. Wrap from 31, with start glitch mid-run
    for (int i = 0; i < 32; i++) begin
      tab_a[i] = 8'($urandom_range(0, 255));
      tab_b[i] = 8'($urandom_range(0, 255));
    end
    run_full(31, 1);

    // Random runs
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) begin
        tab_a[i] = 8'($urandom_range(0, 255));
        tab_b[i] = ($urandom_range(0, 3) == 0) ? tab_a[i]
                                               : 8'($urandom_range(0, 255));
      end
      run_full($urandom_range(0, 31), r[0]);
    end

    // 6a. Abort during bit 1
    tab_a[10] = 200; tab_b[10] = 1;
    tab_a[11] = 201; tab_b[11] = 2;
    wait_idle();
    v0 = n_valid;
    chal_seed = 5'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("ab_in_run", ro_en, 1);
    disturb = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_ro_en", ro_en, 0);
    chk("ab_cnt_clr", cnt_clr, 1);
    chk("ab_resp", resp, 4'b0001);
    repeat (3) @(posedge clk);
    #1;
    chk("ab_still_idle", busy, 0);
    chk("ab_no_valid", n_valid, v0);
    disturb = 1'b0;

    // 6b. Async reset during RUN
    chal_seed = 5'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ar_in_run", ro_en, 1);
    #2;
    disturb = 1'b1;
    rst_n = 1'b1;
    #1;
    chk_reset_vals("ar");
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ar_no_valid", n_valid, v0);
    disturb = 1'b0;

    // Post-reset run still works
    run_full(7, 0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("valid_count", n_valid, n_push);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
